imag_line_buf: RTL
==================

# imag_line_buf

Single-line buffer controller for the smart-eye image pipeline. It sits directly upstream of the dual-port BRAM. It writes each incoming pixel into BRAM port A at its column address and reads the same column from the previous line on port B. It emits the current pixel aligned with the pixel directly above it, which feeds vertical-window filters.

## Interface
Parameters:
- NB_BRAM_DLY, 2, BRAM read latency in clocks; must match the attached BRAM.
- WD_BRAM_ADR, 8, BRAM address width; NB_LINE_PIX must be ≤ 2**WD_BRAM_ADR.
- WD_BRAM_DAT, 32, pixel / BRAM data width.
- NB_LINE_PIX, 256, pixels per line.

Ports:
- i_sys_clk, in, 1, the single clock; BRAM clka/clkb are tied to it externally.
- i_sys_resetn, in, 1, asynchronous active-low reset.
- s_pix_valid, in, 1, input pixel strobe; no backpressure.
- s_pix_data, in, WD_BRAM_DAT, input pixel.
- s_pix_sof, in, 1, first pixel of frame; qualified by valid.
- s_pix_last, in, 1, last pixel of line; qualified by valid.
- m_bram_0_ena / m_bram_0_wea, out, 1 each, port A write strobe (both driven equal).
- m_bram_0_addra, out, WD_BRAM_ADR, write column.
- m_bram_0_dina, out, WD_BRAM_DAT, write data.
- m_bram_0_enb, out, 1, port B read enable.
- m_bram_0_web, out, 1, constant 0.
- m_bram_0_addrb, out, WD_BRAM_ADR, read column.
- m_bram_0_doutb, in, WD_BRAM_DAT, read data.
- m_pix_valid, out, 1, aligned output strobe.
- m_pix_cur, out, WD_BRAM_DAT, delayed current pixel.
- m_pix_prv, out, WD_BRAM_DAT, pixel above; 0 on the first line of a frame.
- m_pix_last, out, 1, delayed s_pix_last.
- m_pix_first, out, 1, high for every pixel of a frame's first line.
- m_line_cnt, out, 16, lines completed in the current frame.
- o_err_len, out, 1, sticky line-length error (see Configuration).

## Operation
- Column counter col (WD_BRAM_ADR bits) advances on each accepted pixel.
- col resets to 0 on s_pix_last or s_pix_sof.
- col also wraps to 0 after NB_LINE_PIX-1 even without last.
- State machine:
  - S_IDLE: after reset; waits for valid&sof, then goes to S_FIRST. Pixels arriving without sof are dropped and get no BRAM access.
  - S_FIRST: on valid&last goes to S_LINE. prv is masked to 0.
  - S_LINE: normal operation. valid&sof returns to S_FIRST and restarts at col 0.
- For each accepted pixel in S_FIRST or S_LINE:
  - Drive ena=wea=enb=1 and addra=addrb=col, with dina=s_pix_data, in the same cycle.
  - The BRAM is read-first, so doutb returns the previous line's value.
- Accepting a pixel means valid is high in S_FIRST/S_LINE, or valid&sof is high in S_IDLE.
- m_line_cnt increments on each accepted last; it clears to 0 on sof.
- Simultaneous sof&last on one pixel is a one-pixel line. The FSM then goes to S_LINE and m_line_cnt becomes 1.

## Timing
- Latency: an accepted pixel at cycle t appears on m_pix_* at t+NB_BRAM_DLY.
- A side pipeline NB_BRAM_DLY deep carries valid, data, last and first.
- m_pix_prv equals m_bram_0_doutb, gated to 0 when the delayed first flag is set.
- The output is registered only in that it directly follows the pipeline; there is no extra register stage.
- Bubbles (valid low) propagate unchanged; gaps between pixels are allowed anywhere.
- Reset values:
  - All m_bram_0_* outputs are 0.
  - m_pix_valid, m_pix_cur, m_pix_last and m_pix_first are 0; the side pipeline clears.
  - m_line_cnt and o_err_len are 0; FSM is in S_IDLE and col is 0.
- Reset asserted mid-line discards the pipeline contents immediately. BRAM contents are not cleared by this block.
- m_line_cnt saturates at 16'hFFFF.

## Configuration
- Macro IMAG_LINE_BUF_ERR_EN.
- Defined: o_err_len sets in either of two cases, and clears only on reset or sof:
  - last is accepted with col ≠ NB_LINE_PIX-1.
  - col wraps without last.
- Undefined: o_err_len is tied to 0 and no checking logic exists. Counter wrap behaviour is unchanged.

## Test plan
All scenarios use NB_LINE_PIX=4, WD_BRAM_DAT=8, NB_BRAM_DLY=2.
- Frame of 3 lines, pixels 1..12 with sof on 1 and last on 4/8/12:
  - Line 1 gives prv=0 with m_pix_first=1.
  - Line 2 gives cur 5..8 paired with prv 1..4; line 3 gives cur 9..12 paired with prv 5..8.
  - m_line_cnt ends at 3.
- Same frame with valid low every other cycle: identical output pairs, each appearing exactly 2 cycles after its input.
- Pixels before the first sof after reset: no BRAM enables, m_pix_valid stays 0.
- New sof after 1.5 lines:
  - The next line reports prv=0 and m_line_cnt restarts at 0.
  - The following line pairs with the new frame's first line.
- Last on col 2 with macro defined: o_err_len goes to 1 and stays set until the next sof. With the macro undefined it stays 0.
- Assert reset during line 2: all outputs are 0 within the same cycle, and the FSM returns to S_IDLE.

Source files
------------

// File: rtl/imag_line_buf.sv
// imag_line_buf: single-line buffer controller for a read-first dual-port BRAM.
// Each accepted pixel is written to BRAM port A at its column. The same column is
// read on port B in the same cycle. The current pixel comes out aligned with the
// pixel directly above it, NB_BRAM_DLY cycles after it was accepted.
//
// Optional feature macro: IMAG_LINE_BUF_ERR_EN enables the sticky line-length error.
//
// Ports:
//   i_sys_clk, i_sys_resetn        clock, asynchronous active-low reset
//   s_pix_valid/data/sof/last      input pixel stream (no backpressure)
//   m_bram_0_*                     dual-port BRAM port A (write) / port B (read)
//   m_pix_valid/cur/prv/last/first aligned output pixel pair
//   m_line_cnt                     lines completed in the current frame (saturating)
//   o_err_len                      sticky line-length error (0 when feature disabled)
module imag_line_buf #(
   parameter int unsigned NB_BRAM_DLY = 2,
   parameter int unsigned WD_BRAM_ADR = 8,
   parameter int unsigned WD_BRAM_DAT = 32,
   parameter int unsigned NB_LINE_PIX = 256
) (
   input  logic                   i_sys_clk,
   input  logic                   i_sys_resetn,
   input  logic                   s_pix_valid,
   input  logic [WD_BRAM_DAT-1:0] s_pix_data,
   input  logic                   s_pix_sof,
   input  logic                   s_pix_last,
   output logic                   m_bram_0_ena,
   output logic                   m_bram_0_wea,
   output logic [WD_BRAM_ADR-1:0] m_bram_0_addra,
   output logic [WD_BRAM_DAT-1:0] m_bram_0_dina,
   output logic                   m_bram_0_enb,
   output logic                   m_bram_0_web,
   output logic [WD_BRAM_ADR-1:0] m_bram_0_addrb,
   input  logic [WD_BRAM_DAT-1:0] m_bram_0_doutb,
   output logic                   m_pix_valid,
   output logic [WD_BRAM_DAT-1:0] m_pix_cur,
   output logic [WD_BRAM_DAT-1:0] m_pix_prv,
   output logic                   m_pix_last,
   output logic                   m_pix_first,
   output logic [15:0]            m_line_cnt,
   output logic                   o_err_len
);

   localparam logic [WD_BRAM_ADR-1:0] COL_MAX = WD_BRAM_ADR'(NB_LINE_PIX - 1);

   typedef enum logic [1:0] {S_IDLE, S_FIRST, S_LINE} state_t;

   state_t                 state;
   logic [WD_BRAM_ADR-1:0] col;
   logic                   accept;
   logic                   pix_first;
   logic [WD_BRAM_ADR-1:0] pix_col;
   logic [15:0]            cnt_base;

   // Acceptance, effective column and first-line flag of the pixel on the input
   always_comb begin
      accept    = s_pix_valid & (s_pix_sof | (state != S_IDLE));
      pix_col   = s_pix_sof ? '0 : col;
      pix_first = s_pix_sof | (state == S_FIRST);
      cnt_base  = s_pix_sof ? 16'd0 : m_line_cnt;
   end

   // BRAM access happens in the acceptance cycle; idle buses are held at 0
   assign m_bram_0_ena   = accept;
   assign m_bram_0_wea   = accept;
   assign m_bram_0_enb   = accept;
   assign m_bram_0_web   = 1'b0;
   assign m_bram_0_addra = accept ? pix_col : '0;
   assign m_bram_0_addrb = accept ? pix_col : '0;
   assign m_bram_0_dina  = accept ? s_pix_data : '0;

   // Frame state, column counter and line counter
   always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) begin
         state      <= S_IDLE;
         col        <= '0;
         m_line_cnt <= '0;
      end else if (accept) begin
         col <= (s_pix_last || (pix_col == COL_MAX)) ? '0 : pix_col + WD_BRAM_ADR'(1);
         if (s_pix_last) begin
            state <= S_LINE;
         end else if (s_pix_sof) begin
            state <= S_FIRST;
         end
         if (s_pix_last && (cnt_base != 16'hFFFF)) begin
            m_line_cnt <= cnt_base + 16'd1;
         end else begin
            m_line_cnt <= cnt_base;
         end
      end
   end

`ifdef IMAG_LINE_BUF_ERR_EN
   logic len_bad;

   // Short line (early last) or long line (wrap without last)
   assign len_bad = s_pix_last ? (pix_col != COL_MAX) : (pix_col == COL_MAX);

   // Sticky error; sof clears it, but a bad length on the sof pixel itself still sets it
   always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) begin
         o_err_len <= 1'b0;
      end else if (accept) begin
         if (len_bad) begin
            o_err_len <= 1'b1;
         end else if (s_pix_sof) begin
            o_err_len <= 1'b0;
         end
      end
   end
`else
   assign o_err_len = 1'b0;
`endif

   logic [NB_BRAM_DLY-1:0] vld_pipe;
   logic [NB_BRAM_DLY-1:0] last_pipe;
   logic [NB_BRAM_DLY-1:0] first_pipe;
   logic [WD_BRAM_DAT-1:0] dat_pipe [NB_BRAM_DLY];

   // Side pipeline matching the BRAM read latency
   always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) begin
         vld_pipe   <= '0;
         last_pipe  <= '0;
         first_pipe <= '0;
         for (int unsigned i = 0; i < NB_BRAM_DLY; i++) begin
            dat_pipe[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NB_BRAM_DLY; i++) begin
            vld_pipe[i]   <= vld_pipe[i-1];
            last_pipe[i]  <= last_pipe[i-1];
            first_pipe[i] <= first_pipe[i-1];
            dat_pipe[i]   <= dat_pipe[i-1];
         end
         vld_pipe[0]   <= accept;
         last_pipe[0]  <= accept & s_pix_last;
         first_pipe[0] <= accept & pix_first;
         dat_pipe[0]   <= accept ? s_pix_data : '0;
      end
   end

   assign m_pix_valid = vld_pipe[NB_BRAM_DLY-1];
   assign m_pix_cur   = dat_pipe[NB_BRAM_DLY-1];
   assign m_pix_last  = last_pipe[NB_BRAM_DLY-1];
   assign m_pix_first = first_pipe[NB_BRAM_DLY-1];
   // Pixel above: masked on a frame's first line and on bubbles
   assign m_pix_prv   = (vld_pipe[NB_BRAM_DLY-1] && !first_pipe[NB_BRAM_DLY-1]) ?
                        m_bram_0_doutb : '0;

endmodule
